// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the write-back arbiter.
// Contents: default register-file geometry and the write-back entry record.
package wb_arbiter_pkg;

    localparam int unsigned REG_FILE_BITS_DEF = 5;
    localparam int unsigned REG_SIZE_DEF      = 32;

    // One buffered register-file write. A cleared valid bit marks a squashed entry.
    typedef struct packed {
        logic                         valid;
        logic [REG_FILE_BITS_DEF-1:0] rd;
        logic [REG_SIZE_DEF-1:0]      value;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-latency write-back buffer: strict FIFO of {valid, rd, value} entries.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push/push_rd/value    enqueue at the tail (caller guarantees count < DEPTH)
//   pop                   dequeue the head (caller guarantees count > 0)
//   squash/squash_rd      invalidate every buffered entry whose rd matches
//   count                 occupancy, 0..DEPTH (squashed entries still occupy slots)
//   head_*                entry at the head
//   pending               one bit per register index with a valid buffered write
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned RF_BITS = REG_FILE_BITS_DEF,
    parameter int unsigned DATA_W  = REG_SIZE_DEF,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [RF_BITS-1:0]      push_rd,
    input  logic [DATA_W-1:0]       push_value,
    input  logic                    pop,
    input  logic                    squash,
    input  logic [RF_BITS-1:0]      squash_rd,
    output logic [CNT_W-1:0]        count,
    output logic                    head_valid,
    output logic [RF_BITS-1:0]      head_rd,
    output logic [DATA_W-1:0]       head_value,
    output logic [2**RF_BITS-1:0]   pending
);

    logic                valid_q [DEPTH];
    logic                valid_d [DEPTH];
    logic [RF_BITS-1:0]  rd_q    [DEPTH];
    logic [RF_BITS-1:0]  rd_d    [DEPTH];
    logic [DATA_W-1:0]   value_q [DEPTH];
    logic [DATA_W-1:0]   value_d [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    always_comb begin
        valid_d  = valid_q;
        rd_d     = rd_q;
        value_d  = value_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Squash only looks at entries already buffered; an entry arriving on
        // this edge is newer than the check and is kept.
        if (squash) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (rd_q[i] == squash_rd)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        // Push targets a free slot, so it never collides with the popped head.
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            rd_d[wr_ptr_q]    = push_rd;
            value_d[wr_ptr_q] = push_value;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '{default: 1'b0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
        rd_q    <= rd_d;
        value_q <= value_d;
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pending[rd_q[i]] = 1'b1;
            end
        end
    end

    assign count      = count_q;
    assign head_valid = valid_q[rd_ptr_q];
    assign head_rd    = rd_q[rd_ptr_q];
    assign head_value = value_q[rd_ptr_q];

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the ALU result path (never stalled, highest
// priority) with buffered long-latency results into one registered
// register-file write port.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_value       ALU result, taken unconditionally
//   mem_valid/mem_ready/mem_rd/...   long-latency result handshake into the buffer
//   we/write_num/in_value            registered write port (committed on negedge)
//   pending_mask                     registers with a long-latency write in flight
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned REG_FILE_BITS = REG_FILE_BITS_DEF,
    parameter int unsigned REG_SIZE      = REG_SIZE_DEF,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [REG_FILE_BITS-1:0]    alu_rd,
    input  logic [REG_SIZE-1:0]         alu_value,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [REG_FILE_BITS-1:0]    mem_rd,
    input  logic [REG_SIZE-1:0]         mem_value,
    output logic                        we,
    output logic [REG_FILE_BITS-1:0]    write_num,
    output logic [REG_SIZE-1:0]         in_value,
    output logic [2**REG_FILE_BITS-1:0] pending_mask
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                        alu_take;
    logic                        mem_push;
    logic                        fifo_pop;
    logic [CNT_W-1:0]            count;
    logic                        head_valid;
    logic [REG_FILE_BITS-1:0]    head_rd;
    logic [REG_SIZE-1:0]         head_value;
    logic [2**REG_FILE_BITS-1:0] fifo_pending;

    logic                        we_q, we_d;
    logic                        from_mem_q, from_mem_d;
    logic [REG_FILE_BITS-1:0]    write_num_q, write_num_d;
    logic [REG_SIZE-1:0]         in_value_q, in_value_d;

    assign mem_ready = count < CNT_W'(FIFO_DEPTH);
    assign alu_take  = alu_valid && (alu_rd != '0);
    // x0 results complete the handshake but are dropped here.
    assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);
    assign fifo_pop  = !alu_take && (count != '0);

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .RF_BITS (REG_FILE_BITS),
        .DATA_W  (REG_SIZE)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (mem_push),
        .push_rd    (mem_rd),
        .push_value (mem_value),
        .pop        (fifo_pop),
        .squash     (alu_take),
        .squash_rd  (alu_rd),
        .count      (count),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_value (head_value),
        .pending    (fifo_pending)
    );

    always_comb begin
        we_d        = 1'b0;
        from_mem_d  = 1'b0;
        write_num_d = write_num_q;
        in_value_d  = in_value_q;
        if (alu_take) begin
            we_d        = 1'b1;
            write_num_d = alu_rd;
            in_value_d  = alu_value;
        end else if (fifo_pop && head_valid) begin
            // A squashed head is still popped, just without a write.
            we_d        = 1'b1;
            from_mem_d  = 1'b1;
            write_num_d = head_rd;
            in_value_d  = head_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            from_mem_q  <= 1'b0;
            write_num_q <= '0;
            in_value_q  <= '0;
        end else begin
            we_q        <= we_d;
            from_mem_q  <= from_mem_d;
            write_num_q <= write_num_d;
            in_value_q  <= in_value_d;
        end
    end

    assign we        = we_q;
    assign write_num = write_num_q;
    assign in_value  = in_value_q;

    always_comb begin
        pending_mask = fifo_pending;
        if (we_q && from_mem_q) begin
            pending_mask[write_num_q] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter REG_FILE_BITS, default 5, register index width.
REQ-002 SHALL have parameter REG_SIZE, default 32, data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, long-latency write buffer entries (power of 2, at least 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port alu_valid  input  1  ALU-path result present this cycle; never back-pressured.
REQ-007 SHALL have port alu_rd  input  REG_FILE_BITS  ALU destination index.
REQ-008 SHALL have port alu_value  input  REG_SIZE  ALU result.
REQ-009 SHALL have port mem_valid  input  1  long-latency result offered (load/mul/div).
REQ-010 SHALL have port mem_ready  output  1  buffer accepts offered result.
REQ-011 SHALL have port mem_rd  input  REG_FILE_BITS  long-latency destination index.
REQ-012 SHALL have port mem_value  input  REG_SIZE  long-latency result.
REQ-013 SHALL have port we  output  1  register-file write enable.
REQ-014 SHALL have port write_num  output  REG_FILE_BITS  register-file write index.
REQ-015 SHALL have port in_value  output  REG_SIZE  register-file write data.
REQ-016 SHALL have port pending_mask  output  2**REG_FILE_BITS  bit r set while a long-latency write to r is buffered or held in the output register.

Function
REQ-017 SHALL drive we, write_num, in_value from registers; the register file commits them on the following negedge.
REQ-018 SHALL register an ALU write (alu_valid=1, alu_rd!=0) onto the outputs at the next posedge: latency 1 cycle.
REQ-019 SHALL give the ALU path absolute priority over the buffer for the output register.
REQ-020 SHALL complete a mem handshake on a posedge with mem_valid=1 and mem_ready=1, pushing {mem_rd, mem_value} into the FIFO tail.
REQ-021 SHALL drive mem_ready = (count < FIFO_DEPTH), combinational from count only; no same-cycle bypass when full.
REQ-022 SHALL pop the FIFO head into the output register on any posedge where count>0 and no ALU write is taken; minimum mem latency 2 cycles (push, then drain).
REQ-023 SHALL allow push and pop on the same posedge; count unchanged; order preserved (strict FIFO).
REQ-024 SHALL keep count in 0..FIFO_DEPTH with wrap-around read/write pointers of log2(FIFO_DEPTH) bits.
REQ-025 SHALL discard writes to index 0 on both paths: ALU write to x0 produces we=0 and frees the slot for a drain; mem write to x0 is accepted (handshake completes) but not enqueued.
REQ-026 SHALL drive we=0 with write_num and in_value held at previous values on cycles with nothing to write.
REQ-027 SHALL squash (invalidate, not write) every buffered entry whose rd equals an accepted ALU rd on that posedge; squashed entries are popped without asserting we.
REQ-028 SHALL compute pending_mask combinationally as the OR over valid FIFO entries plus the output register when it holds a mem-sourced write; bit 0 always 0.

Reset
REQ-029 SHALL, while rst=1 at posedge, clear count, pointers, all entry-valid bits; we=0, write_num=0, in_value=0.
REQ-030 SHALL drop buffered entries when rst asserts mid-operation; mem_ready reads 1 and pending_mask all-zero in the cycle after reset.

Structure
REQ-031 SHALL take REG_FILE_BITS/REG_SIZE defaults and a wb_entry_t typedef {valid, rd, value} from the shared core package.
REQ-032 SHALL implement the buffer as sub-module wb_fifo (push/pop/count/entry-visibility for the mask and squash compare); arbitration and output register stay in wb_arbiter.

Verification
REQ-033 SHALL cover: ALU write rd=5 value 0xDEADBEEF -> next cycle we=1, write_num=5, in_value=0xDEADBEEF.
REQ-034 SHALL cover: mem rd=7 0x11 with ALU rd=3 same cycle -> cycle+1 writes x3, cycle+2 writes x7; pending_mask[7]=1 until x7 write registered and held.
REQ-035 SHALL cover: 4 mem pushes with ALU valid every cycle -> count=4, mem_ready=0; fifth mem_valid stalls; ALU idle then drains in order 4 cycles.
REQ-036 SHALL cover: ALU write x0 and mem write x0 -> we stays 0, mem handshake completes, pending_mask=0.
REQ-037 SHALL cover: buffered mem rd=9, ALU rd=9 0x22 -> single write x9=0x22, no later write of x9.
REQ-038 SHALL cover: rst asserted with 3 entries buffered -> no writes after, mem_ready=1, pending_mask=0.
